bsnn_layer_sequencer: RTL and testbench
=======================================

BSNN_LAYER_SEQUENCER -- requirements
Module: bsnn_layer_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 256, meaning input row width and shared layer input bus width.
REQ-002 SHALL have parameter N_NEURONS, default 256, meaning spike vector width per layer; N_NEURONS <= WIDTH.
REQ-003 SHALL have parameter NUM_LAYERS, default 6, meaning number of layers time-multiplexed onto one bsnn_addmm_top instance.
REQ-004 SHALL have parameter LAYER_LATENCY, default 1, meaning cycles from layer_valid to valid layer_spike; minimum 1.
REQ-005 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_row (input, WIDTH): input row handshake.
REQ-008 SHALL have port layer_valid, output, 1, one-cycle issue strobe to the layer.
REQ-009 SHALL have port layer_input, output, WIDTH, row presented to the layer.
REQ-010 SHALL have port layer_sel, output, $clog2(NUM_LAYERS) (min 1), weight bank index for the current layer.
REQ-011 SHALL have port layer_spike, input, N_NEURONS, spike vector returned by the layer.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_spike (output, N_NEURONS): result handshake.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-015 IDLE: in_ready=1; on in_valid&&in_ready, SHALL latch in_row into row_reg, clear layer_idx, and go to ISSUE.
REQ-016 ISSUE: layer_valid=1 for exactly one cycle; layer_sel=layer_idx; SHALL clear lat_cnt and go to WAIT.
REQ-017 layer_input SHALL be row_reg when layer_idx==0, else spike_reg zero-extended to WIDTH; it SHALL be held stable in ISSUE and WAIT.
REQ-018 WAIT: lat_cnt SHALL increment each cycle; in the cycle lat_cnt==LAYER_LATENCY-1, layer_spike SHALL be sampled into spike_reg.
REQ-019 At that sample edge: if layer_idx==NUM_LAYERS-1, go to DONE; else increment layer_idx and go to ISSUE.
REQ-020 Per-layer cost SHALL be 1+LAYER_LATENCY cycles; out_valid SHALL rise exactly 1+NUM_LAYERS*(1+LAYER_LATENCY) cycles after the input accept edge.
REQ-021 DONE: out_valid=1, out_spike=spike_reg; both SHALL hold stable until out_valid&&out_ready, then go to IDLE.
REQ-022 in_ready SHALL be 0 in ISSUE, WAIT, and DONE; in_valid there SHALL be ignored and not queued.
REQ-023 out_ready asserted outside DONE SHALL have no effect.
REQ-024 layer_sel SHALL never exceed NUM_LAYERS-1; layer_idx SHALL not wrap within a job.
REQ-025 NUM_LAYERS==1 SHALL go ISSUE->WAIT->DONE with layer_input=row_reg.

Reset
REQ-026 With rst=1 at a clock edge, state SHALL become IDLE, layer_idx=0, lat_cnt=0, spike_reg=0, and row_reg=0.
REQ-027 During and after reset, outputs SHALL be: in_ready=1 after release, layer_valid=0, out_valid=0, busy=0, out_spike=0, and layer_sel=0.
REQ-028 Reset mid-job SHALL abort the job silently; no out_valid SHALL follow for the aborted row.

Structure
REQ-029 The FSM state enum and a layer-index width function SHALL live in shared package bsnn_pkg.
REQ-030 The block SHALL be a single module without sub-modules; the layer is external, and a top pairs this block with one bsnn_addmm_top whose weight_matrix_flat is selected by layer_sel.

Verification
REQ-031 Bench SHALL cover: NUM_LAYERS=3, LAYER_LATENCY=2, accept at cycle 0 -> layer_valid at cycles 1, 4, 7 with layer_sel 0, 1, 2; out_valid at cycle 10.
REQ-032 Bench SHALL cover: model layer returns input XOR layer_sel pattern -> out_spike equals the three-stage golden chain; layer_input equals row_reg only in layer 0.
REQ-033 Bench SHALL cover: out_ready held low 5 cycles in DONE -> out_valid and out_spike stable; in_ready=0 throughout; IDLE on the cycle after the handshake.
REQ-034 Bench SHALL cover: in_valid pulsed during WAIT -> not accepted, and the result is unchanged.
REQ-035 Bench SHALL cover: rst asserted in WAIT of layer 1 -> next cycle IDLE, out_valid=0, and a fresh job completes correctly.
REQ-036 Bench SHALL cover: NUM_LAYERS=1, LAYER_LATENCY=1 -> out_valid 3 cycles after accept.

Source files
------------

// File: rtl/bsnn_pkg.sv
// Shared types and helpers for the BSNN layer sequencer and its neighbours.
package bsnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsnn_layer_sequencer.sv
// Time-multiplexes one external BSNN layer across NUM_LAYERS weight banks,
// feeding each layer's spikes back as the next layer's input.
module bsnn_layer_sequencer
  import bsnn_pkg::*;
#(
  parameter int WIDTH         = 256,
  parameter int N_NEURONS     = 256,
  parameter int NUM_LAYERS    = 6,
  parameter int LAYER_LATENCY = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     in_row,
  output logic                                 layer_valid,
  output logic [WIDTH-1:0]                     layer_input,
  output logic [idx_width(NUM_LAYERS)-1:0]     layer_sel,
  input  logic [N_NEURONS-1:0]                 layer_spike,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [N_NEURONS-1:0]                 out_spike,
  output logic                                 busy
);

  localparam int SW = idx_width(NUM_LAYERS);
  localparam int CW = idx_width(LAYER_LATENCY);
  localparam logic [SW-1:0] LAST_IDX = SW'(NUM_LAYERS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(LAYER_LATENCY - 1);

  seq_state_e           state_q;
  logic [SW-1:0]        idx_q;
  logic [CW-1:0]        lat_q;
  logic [WIDTH-1:0]     row_q;
  logic [N_NEURONS-1:0] spike_q;
  logic                 in_ready_q;
  logic                 layer_valid_q;
  logic                 out_valid_q;
  logic                 busy_q;

  // Sequencer FSM; control outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      lat_q         <= '0;
      row_q         <= '0;
      spike_q       <= '0;
      in_ready_q    <= 1'b1;
      layer_valid_q <= 1'b0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            row_q         <= in_row;
            idx_q         <= '0;
            state_q       <= ST_ISSUE;
            in_ready_q    <= 1'b0;
            layer_valid_q <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        ST_ISSUE: begin
          lat_q         <= '0;
          state_q       <= ST_WAIT;
          layer_valid_q <= 1'b0;
        end
        ST_WAIT: begin
          if (lat_q == LAST_CNT) begin
            spike_q <= layer_spike;
            lat_q   <= '0;
            if (idx_q == LAST_IDX) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end else begin
              idx_q         <= idx_q + SW'(1);
              state_q       <= ST_ISSUE;
              layer_valid_q <= 1'b1;
            end
          end else begin
            lat_q <= lat_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          idx_q         <= '0;
          lat_q         <= '0;
          in_ready_q    <= 1'b1;
          layer_valid_q <= 1'b0;
          out_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  // Layer 0 sees the raw row; later layers see the previous spikes, zero-extended.
  assign layer_input = (idx_q == '0) ? row_q : WIDTH'(spike_q);
  assign layer_sel   = idx_q;
  assign out_spike   = spike_q;
  assign in_ready    = in_ready_q;
  assign layer_valid = layer_valid_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bsnn_layer_sequencer.sv
// Self-checking bench: a 3-layer/latency-2 instance and a 1-layer/latency-1 instance.
module tb_bsnn_layer_sequencer;

  localparam int W  = 16;
  localparam int N  = 12;
  localparam int NL = 3;
  localparam int LA = 2;
  localparam int PER = 1 + LA;

  logic clk, rst;
  int n_cmp = 0;
  int n_bad = 0;

  logic          in_valid_a, in_ready_a, lay_valid_a, out_valid_a, out_ready_a, busy_a;
  logic [W-1:0]  in_row_a, lay_in_a;
  logic [1:0]    lay_sel_a;
  logic [N-1:0]  lay_spike_a, out_spike_a;

  logic          in_valid_b, in_ready_b, lay_valid_b, out_valid_b, out_ready_b, busy_b;
  logic [W-1:0]  in_row_b, lay_in_b;
  logic [0:0]    lay_sel_b;
  logic [N-1:0]  lay_spike_b, out_spike_b;

  bsnn_layer_sequencer #(.WIDTH(W), .N_NEURONS(N), .NUM_LAYERS(NL), .LAYER_LATENCY(LA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_row(in_row_a),
    .layer_valid(lay_valid_a), .layer_input(lay_in_a), .layer_sel(lay_sel_a),
    .layer_spike(lay_spike_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_spike(out_spike_a), .busy(busy_a));

  bsnn_layer_sequencer #(.WIDTH(W), .N_NEURONS(N), .NUM_LAYERS(1), .LAYER_LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_row(in_row_b),
    .layer_valid(lay_valid_b), .layer_input(lay_in_b), .layer_sel(lay_sel_b),
    .layer_spike(lay_spike_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_spike(out_spike_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] pat(input int sel);
    return 12'(sel + 1) * 12'h9C5;
  endfunction

  // Reference: each layer XORs its bank pattern into the low N bits.
  function automatic logic [N-1:0] model_chain(input logic [W-1:0] row, input int layers);
    logic [N-1:0] s;
    s = row[N-1:0];
    for (int l = 0; l < layers; l++) s = s ^ pat(l);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Layer models: result is valid only in the cycle LATENCY after issue, noise otherwise.
  int since_a = 100;
  logic [N-1:0] res_a = '0;
  always begin
    @(posedge clk); #1;
    if (lay_valid_a) begin
      since_a = 0;
      res_a = lay_in_a[N-1:0] ^ pat(int'(lay_sel_a));
    end else if (since_a < 100) begin
      since_a++;
    end
    lay_spike_a = (since_a == LA) ? res_a : 12'($urandom);
  end

  int since_b = 100;
  logic [N-1:0] res_b = '0;
  always begin
    @(posedge clk); #1;
    if (lay_valid_b) begin
      since_b = 0;
      res_b = lay_in_b[N-1:0] ^ pat(int'(lay_sel_b));
    end else if (since_b < 100) begin
      since_b++;
    end
    lay_spike_b = (since_b == 1) ? res_b : 12'($urandom);
  end

  task automatic run_a(input logic [W-1:0] row, input logic [N-1:0] exp_spike,
                       input int hold, input bit pulse);
    logic [N-1:0] chain;
    logic [W-1:0] exp_in;
    int l;
    chk("a_idle_in_ready", 64'(in_ready_a), 64'(1));
    chk("a_idle_busy", 64'(busy_a), 64'(0));
    in_valid_a = 1'b1;
    in_row_a = row;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_row_a = 16'($urandom);
    chain = row[N-1:0];
    for (int k = 1; k < 1 + NL * PER; k++) begin
      l = (k - 1) / PER;
      if (k > 1 && (k - 1) % PER == 0) chain = chain ^ pat(l - 1);
      exp_in = (l == 0) ? row : W'(chain);
      chk("a_layer_valid", 64'(lay_valid_a), 64'((k - 1) % PER == 0));
      chk("a_layer_sel", 64'(lay_sel_a), 64'(l));
      chk("a_layer_input", 64'(lay_in_a), 64'(exp_in));
      chk("a_busy", 64'(busy_a), 64'(1));
      chk("a_in_ready_busy", 64'(in_ready_a), 64'(0));
      chk("a_out_valid_early", 64'(out_valid_a), 64'(0));
      if (pulse && k == 5) begin
        in_valid_a = 1'b1;
        in_row_a = ~row;
      end else begin
        in_valid_a = 1'b0;
      end
      out_ready_a = 1'(k % 2);
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    out_ready_a = (hold == 0);
    chk("a_out_valid_rise", 64'(out_valid_a), 64'(1));
    chk("a_out_spike", 64'(out_spike_a), 64'(exp_spike));
    chk("a_done_busy", 64'(busy_a), 64'(1));
    chk("a_done_layer_valid", 64'(lay_valid_a), 64'(0));
    for (int h = 0; h < hold; h++) begin
      in_valid_a = pulse;
      out_ready_a = (h == hold - 1);
      @(posedge clk); #1;
      if (h < hold - 1) begin
        chk("a_hold_out_valid", 64'(out_valid_a), 64'(1));
        chk("a_hold_out_spike", 64'(out_spike_a), 64'(exp_spike));
        chk("a_hold_in_ready", 64'(in_ready_a), 64'(0));
      end
    end
    if (hold == 0) begin
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b0;
    chk("a_post_out_valid", 64'(out_valid_a), 64'(0));
    chk("a_post_in_ready", 64'(in_ready_a), 64'(1));
    chk("a_post_busy", 64'(busy_a), 64'(0));
    @(posedge clk); #1;
    chk("a_not_queued", 64'(busy_a), 64'(0));
  endtask

  typedef struct {
    logic [W-1:0] row;
    int           hold;
    bit           pulse;
    logic [N-1:0] exp_spike;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b1;
    in_valid_a = 1'b0; in_row_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_row_b = '0; out_ready_b = 1'b0;
    lay_spike_a = '0; lay_spike_b = '0;

    for (int i = 0; i < 8; i++) begin
      vecs[i].row   = (i == 0) ? 16'h0000 : (i == 1) ? 16'hFFFF : 16'($urandom);
      vecs[i].hold  = (i == 2) ? 5 : int'($urandom_range(0, 3));
      vecs[i].pulse = (i == 3) || (i == 6);
      vecs[i].exp_spike = model_chain(vecs[i].row, NL);
    end

    @(posedge clk); #1;
    chk("rst_layer_valid", 64'(lay_valid_a), 64'(0));
    chk("rst_out_valid", 64'(out_valid_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_out_spike", 64'(out_spike_a), 64'(0));
    chk("rst_layer_sel", 64'(lay_sel_a), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready_a), 64'(1));
    chk("rst_b_in_ready", 64'(in_ready_b), 64'(1));

    for (int i = 0; i < 8; i++) run_a(vecs[i].row, vecs[i].exp_spike, vecs[i].hold, vecs[i].pulse);

    // Reset in the wait phase of layer 1 aborts the job silently.
    in_valid_a = 1'b1;
    in_row_a = 16'hBEEF;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("abort_sel_in_wait", 64'(lay_sel_a), 64'(1));
    chk("abort_lv_in_wait", 64'(lay_valid_a), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 64'(out_valid_a), 64'(0));
    chk("abort_busy", 64'(busy_a), 64'(0));
    chk("abort_in_ready", 64'(in_ready_a), 64'(1));
    chk("abort_layer_sel", 64'(lay_sel_a), 64'(0));
    chk("abort_out_spike", 64'(out_spike_a), 64'(0));
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("abort_no_out_valid", 64'(out_valid_a), 64'(0));
    end
    run_a(16'h1234, model_chain(16'h1234, NL), 1, 1'b0);

    // Single-layer instance: out_valid three cycles after accept.
    for (int j = 0; j < 3; j++) begin
      logic [W-1:0] row;
      row = 16'($urandom);
      in_valid_b = 1'b1;
      in_row_b = row;
      @(posedge clk); #1;
      in_valid_b = 1'b0;
      chk("b_layer_valid_1", 64'(lay_valid_b), 64'(1));
      chk("b_layer_input", 64'(lay_in_b), 64'(row));
      chk("b_layer_sel", 64'(lay_sel_b), 64'(0));
      chk("b_out_valid_1", 64'(out_valid_b), 64'(0));
      @(posedge clk); #1;
      chk("b_layer_valid_2", 64'(lay_valid_b), 64'(0));
      chk("b_out_valid_2", 64'(out_valid_b), 64'(0));
      chk("b_layer_input_2", 64'(lay_in_b), 64'(row));
      @(posedge clk); #1;
      chk("b_out_valid_3", 64'(out_valid_b), 64'(1));
      chk("b_out_spike", 64'(out_spike_b), 64'(model_chain(row, 1)));
      out_ready_b = 1'b1;
      @(posedge clk); #1;
      out_ready_b = 1'b0;
      chk("b_post_out_valid", 64'(out_valid_b), 64'(0));
      chk("b_post_in_ready", 64'(in_ready_b), 64'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
